// File: rtl/iir_sos_serial.sv
// Time-multiplexed biquad cascade. One shared datapath runs a feedback (FB) cycle
// and then a feed-forward (FF) cycle for each of N_SEC sections per accepted sample.
module iir_sos_serial #(
  parameter int DATA_W  = 17,
  parameter int COEF_W  = 17,
  parameter int FRAC    = 14,
  parameter int STATE_W = 40,
  parameter int N_SEC   = 48,
  parameter int ADDR_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     coef_we,
  input  logic [ADDR_W-1:0]        coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic                     coef_err,
  input  logic                     clear_state,
  output logic                     busy,
  output logic                     sat_flag
);
  localparam int SEC_W  = (N_SEC > 1) ? $clog2(N_SEC) : 1;
  localparam int N_COEF = 5 * N_SEC;
  localparam int ACC_W  = COEF_W + STATE_W + 2;
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << FRAC);

  function automatic logic signed [STATE_W-1:0] sat_state(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] hi, lo;
    hi = ACC_W'({1'b0, {(STATE_W-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return {1'b0, {(STATE_W-1){1'b1}}};
    if (v < lo) return {1'b1, {(STATE_W-1){1'b0}}};
    return v[STATE_W-1:0];
  endfunction

  function automatic logic ovf_state(input logic signed [ACC_W-1:0] v);
    return v != ACC_W'(sat_state(v));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [STATE_W-1:0] v);
    logic signed [STATE_W-1:0] hi, lo;
    hi = STATE_W'({1'b0, {(DATA_W-1){1'b1}}});
    lo = ~hi;
    if (v > hi) return {1'b0, {(DATA_W-1){1'b1}}};
    if (v < lo) return {1'b1, {(DATA_W-1){1'b0}}};
    return v[DATA_W-1:0];
  endfunction

  function automatic logic ovf_out(input logic signed [STATE_W-1:0] v);
    return v != STATE_W'(sat_out(v));
  endfunction

  typedef enum logic [1:0] {IDLE, FB, FF, OUT} state_t;

  state_t                     state_q, state_d;
  logic [SEC_W-1:0]           sec_q, sec_d;
  logic signed [STATE_W-1:0]  x_q, x_d, w_q, w_d;
  logic signed [DATA_W-1:0]   out_data_q, out_data_d;
  logic                       sat_q, sat_d, coef_err_q, coef_err_d;
  logic signed [COEF_W-1:0]   coef_q [N_COEF];
  logic signed [COEF_W-1:0]   coef_d [N_COEF];
  logic signed [STATE_W-1:0]  w1_q [N_SEC];
  logic signed [STATE_W-1:0]  w1_d [N_SEC];
  logic signed [STATE_W-1:0]  w2_q [N_SEC];
  logic signed [STATE_W-1:0]  w2_d [N_SEC];

  logic signed [COEF_W-1:0]   b0_s, b1_s, b2_s, a1_s, a2_s;
  logic signed [STATE_W-1:0]  w1_s, w2_s, y_s;
  logic signed [ACC_W-1:0]    fb_acc, ff_acc;
  logic                       coef_ok;

  assign coef_ok = 32'(coef_addr) < 32'(N_COEF);

  // Operand mux for the active section, then the shared FB / FF arithmetic
  always_comb begin
    b0_s = '0; b1_s = '0; b2_s = '0; a1_s = '0; a2_s = '0;
    w1_s = '0; w2_s = '0;
    for (int i = 0; i < N_SEC; i++) begin
      if (sec_q == SEC_W'(i)) begin
        b0_s = coef_q[5*i];
        b1_s = coef_q[5*i+1];
        b2_s = coef_q[5*i+2];
        a1_s = coef_q[5*i+3];
        a2_s = coef_q[5*i+4];
        w1_s = w1_q[i];
        w2_s = w2_q[i];
      end
    end
    fb_acc = ACC_W'(x_q) - ((ACC_W'(a1_s) * ACC_W'(w1_s) + ACC_W'(a2_s) * ACC_W'(w2_s)) >>> FRAC);
    ff_acc = (ACC_W'(b0_s) * ACC_W'(w_q) + ACC_W'(b1_s) * ACC_W'(w1_s)
              + ACC_W'(b2_s) * ACC_W'(w2_s)) >>> FRAC;
    y_s = sat_state(ff_acc);
  end

  always_comb begin
    state_d    = state_q;
    sec_d      = sec_q;
    x_d        = x_q;
    w_d        = w_q;
    out_data_d = out_data_q;
    sat_d      = sat_q;
    coef_err_d = 1'b0;
    coef_d     = coef_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    case (state_q)
      IDLE: begin
        if (clear_state) begin
          for (int i = 0; i < N_SEC; i++) begin
            w1_d[i] = '0;
            w2_d[i] = '0;
          end
          sat_d = 1'b0;
        end
        if (coef_we) begin
          if (coef_ok) begin
            for (int j = 0; j < N_COEF; j++)
              if (coef_addr == ADDR_W'(j)) coef_d[j] = coef_wdata;
          end else begin
            coef_err_d = 1'b1;
          end
        end
        if (in_valid) begin
          x_d     = STATE_W'(in_data);
          sec_d   = '0;
          state_d = FB;
        end
      end
      FB: begin
        w_d = sat_state(fb_acc);
        if (ovf_state(fb_acc)) sat_d = 1'b1;
        state_d = FF;
      end
      FF: begin
        x_d = y_s;
        if (ovf_state(ff_acc)) sat_d = 1'b1;
        for (int i = 0; i < N_SEC; i++) begin
          if (sec_q == SEC_W'(i)) begin
            w2_d[i] = w1_q[i];
            w1_d[i] = w_q;
          end
        end
        if (sec_q == SEC_W'(N_SEC-1)) begin
          out_data_d = sat_out(y_s);
          if (ovf_out(y_s)) sat_d = 1'b1;
          state_d = OUT;
        end else begin
          sec_d   = sec_q + 1'b1;
          state_d = FB;
        end
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Writes are only legal between samples
    if (coef_we && (state_q != IDLE)) coef_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sec_q      <= '0;
      x_q        <= '0;
      w_q        <= '0;
      out_data_q <= '0;
      sat_q      <= 1'b0;
      coef_err_q <= 1'b0;
      for (int j = 0; j < N_COEF; j++) coef_q[j] <= (j % 5 == 0) ? COEF_ONE : '0;
      for (int i = 0; i < N_SEC; i++) begin
        w1_q[i] <= '0;
        w2_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      x_q        <= x_d;
      w_q        <= w_d;
      out_data_q <= out_data_d;
      sat_q      <= sat_d;
      coef_err_q <= coef_err_d;
      coef_q     <= coef_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign coef_err  = coef_err_q;
  assign sat_flag  = sat_q;
endmodule

// File: tb/tb_iir_sos_serial.sv
// Bench for iir_sos_serial: a 48-section and a 1-section instance, checked against
// constants and an arithmetic cascade model.
`timescale 1ns/1ps
module tb_iir_sos_serial;
  localparam int FR = 14, SW = 40, DW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [2], iv [2], ir [2], ov [2], ordy [2], cwe [2], cerr [2], clr [2], bsy [2], satf [2];
  logic signed [16:0] idata [2], odata [2], cdata [2];
  logic [7:0] caddr [2];

  int n_checks = 0, n_pass = 0;
  longint cm [2][240];
  longint w1m [2][48];
  longint w2m [2][48];
  bit msat [2];

  iir_sos_serial #(.N_SEC(48)) u_dut48 (
    .clk(clk), .reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0]), .coef_we(cwe[0]),
    .coef_addr(caddr[0]), .coef_wdata(cdata[0]), .coef_err(cerr[0]),
    .clear_state(clr[0]), .busy(bsy[0]), .sat_flag(satf[0]));

  iir_sos_serial #(.N_SEC(1)) u_dut1 (
    .clk(clk), .reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1]), .coef_we(cwe[1]),
    .coef_addr(caddr[1]), .coef_wdata(cdata[1]), .coef_err(cerr[1]),
    .clear_state(clr[1]), .busy(bsy[1]), .sat_flag(satf[1]));

  function automatic int nsec(input int u);
    return (u == 0) ? 48 : 1;
  endfunction

  function automatic longint satw(input longint v, input int w);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset(input int u);
    for (int a = 0; a < 240; a++) cm[u][a] = (a % 5 == 0) ? 16384 : 0;
    for (int s = 0; s < 48; s++) begin w1m[u][s] = 0; w2m[u][s] = 0; end
    msat[u] = 1'b0;
  endtask

  task automatic model_clear(input int u);
    for (int s = 0; s < 48; s++) begin w1m[u][s] = 0; w2m[u][s] = 0; end
    msat[u] = 1'b0;
  endtask

  // Direct-form-II cascade from the filter equations, with saturation on every stage
  task automatic model_step(input int u, input longint x, output longint yo);
    longint v, w, y, t;
    v = x;
    for (int s = 0; s < nsec(u); s++) begin
      t = v - ((cm[u][5*s+3] * w1m[u][s] + cm[u][5*s+4] * w2m[u][s]) >>> FR);
      w = satw(t, SW);
      if (w != t) msat[u] = 1'b1;
      t = (cm[u][5*s] * w + cm[u][5*s+1] * w1m[u][s] + cm[u][5*s+2] * w2m[u][s]) >>> FR;
      y = satw(t, SW);
      if (y != t) msat[u] = 1'b1;
      w2m[u][s] = w1m[u][s];
      w1m[u][s] = w;
      v = y;
    end
    yo = satw(v, DW);
    if (yo != v) msat[u] = 1'b1;
  endtask

  task automatic wr_coef(input int u, input int addr, input longint val);
    @(negedge clk); cwe[u] = 1'b1; caddr[u] = 8'(addr); cdata[u] = 17'(val);
    @(negedge clk); cwe[u] = 1'b0;
    if (addr < 5 * nsec(u)) cm[u][addr] = val;
  endtask

  task automatic pulse_clear(input int u);
    @(negedge clk); clr[u] = 1'b1;
    @(negedge clk); clr[u] = 1'b0;
    model_clear(u);
  endtask

  // lat = edges after the accepting edge until out_valid is seen
  task automatic send(input int u, input int x, output int y, output int lat);
    @(negedge clk); iv[u] = 1'b1; idata[u] = 17'(x);
    @(negedge clk); iv[u] = 1'b0;
    lat = 0;
    while (!ov[u] && lat < 400) begin @(negedge clk); lat++; end
    y = int'(odata[u]);
    n_checks++;
    if (ov[u] !== 1'b1) $display("FAIL send_timeout u=%0d: out_valid=%b after %0d cycles, want 1", u, ov[u], lat);
    else n_pass++;
    if (ordy[u]) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      n_checks++; if (ir[u] !== 1'b1) $display("FAIL reset_in_ready u=%0d: got %b want 1", u, ir[u]); else n_pass++;
      n_checks++; if (ov[u] !== 1'b0) $display("FAIL reset_out_valid u=%0d: got %b want 0", u, ov[u]); else n_pass++;
      n_checks++; if (odata[u] !== 17'sd0) $display("FAIL reset_out_data u=%0d: got %0d want 0", u, odata[u]); else n_pass++;
      n_checks++; if (bsy[u] !== 1'b0) $display("FAIL reset_busy u=%0d: got %b want 0", u, bsy[u]); else n_pass++;
      n_checks++; if (cerr[u] !== 1'b0) $display("FAIL reset_coef_err u=%0d: got %b want 0", u, cerr[u]); else n_pass++;
      n_checks++; if (satf[u] !== 1'b0) $display("FAIL reset_sat_flag u=%0d: got %b want 0", u, satf[u]); else n_pass++;
    end
  endtask

  task automatic test_identity48();
    int y, lat;
    send(0, 1000, y, lat);
    n_checks++; if (y != 1000) $display("FAIL identity_data: got %0d want 1000", y); else n_pass++;
    n_checks++; if (lat != 96) $display("FAIL identity_latency: got %0d want 96", lat); else n_pass++;
    n_checks++; if (satf[0] !== 1'b0) $display("FAIL identity_sat: got %b want 0", satf[0]); else n_pass++;
  endtask

  task automatic test_random48();
    int y, lat, x, v, k;
    longint ye;
    for (int a = 0; a < 240; a++) begin
      k = a % 5;
      if (k == 0) v = int'($urandom_range(8192, 16384));
      else if (k < 3) v = int'($urandom_range(0, 4096)) - 2048;
      else v = int'($urandom_range(0, 8192)) - 4096;
      wr_coef(0, a, v);
    end
    pulse_clear(0);
    for (int n = 0; n < 6; n++) begin
      x = int'($urandom_range(0, 60000)) - 30000;
      model_step(0, x, ye);
      send(0, x, y, lat);
      n_checks++; if (longint'(y) != ye) $display("FAIL random_data n=%0d x=%0d: got %0d want %0d", n, x, y, ye); else n_pass++;
      n_checks++; if (satf[0] !== msat[0]) $display("FAIL random_sat n=%0d: got %b want %b", n, satf[0], msat[0]); else n_pass++;
    end
  endtask

  task automatic test_gain_half();
    int y, lat;
    wr_coef(1, 0, 8192);
    send(1, 1000, y, lat);
    n_checks++; if (y != 500) $display("FAIL half_pos: got %0d want 500", y); else n_pass++;
    n_checks++; if (lat != 2) $display("FAIL half_latency: got %0d want 2", lat); else n_pass++;
    send(1, -1000, y, lat);
    n_checks++; if (y != -500) $display("FAIL half_neg: got %0d want -500", y); else n_pass++;
  endtask

  task automatic test_decay();
    int y, lat, xin;
    int exp_d [4];
    exp_d = '{16384, 8192, 4096, 2048};
    wr_coef(1, 0, 16384);
    wr_coef(1, 3, -8192);
    pulse_clear(1);
    for (int n = 0; n < 4; n++) begin
      xin = (n == 0) ? 16384 : 0;
      send(1, xin, y, lat);
      n_checks++; if (y != exp_d[n]) $display("FAIL decay n=%0d: got %0d want %0d", n, y, exp_d[n]); else n_pass++;
    end
    pulse_clear(1);
    for (int n = 0; n < 2; n++) begin
      xin = (n == 0) ? 16384 : 0;
      send(1, xin, y, lat);
      n_checks++; if (y != exp_d[n]) $display("FAIL decay_cleared n=%0d: got %0d want %0d", n, y, exp_d[n]); else n_pass++;
    end
  endtask

  task automatic test_sat();
    int y, lat;
    pulse_clear(1);
    wr_coef(1, 3, 0);
    wr_coef(1, 0, 32768);
    send(1, 40000, y, lat);
    n_checks++; if (y != 65535) $display("FAIL sat_data: got %0d want 65535", y); else n_pass++;
    n_checks++; if (satf[1] !== 1'b1) $display("FAIL sat_flag_set: got %b want 1", satf[1]); else n_pass++;
    send(1, 100, y, lat);
    n_checks++; if (y != 200) $display("FAIL sat_after_data: got %0d want 200", y); else n_pass++;
    n_checks++; if (satf[1] !== 1'b1) $display("FAIL sat_sticky: got %b want 1", satf[1]); else n_pass++;
    pulse_clear(1);
    n_checks++; if (satf[1] !== 1'b0) $display("FAIL sat_cleared: got %b want 0", satf[1]); else n_pass++;
  endtask

  task automatic test_backpressure();
    int y, lat;
    ordy[1] = 1'b0;
    send(1, 300, y, lat);
    n_checks++; if (y != 600) $display("FAIL bp_data: got %0d want 600", y); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (ov[1] !== 1'b1 || ir[1] !== 1'b0 || odata[1] !== 17'sd600)
        $display("FAIL bp_hold c=%0d: valid=%b ready=%b data=%0d want 1 0 600", c, ov[1], ir[1], odata[1]);
      else n_pass++;
    end
    ordy[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1) $display("FAIL bp_release: valid=%b ready=%b want 0 1", ov[1], ir[1]);
    else n_pass++;
  endtask

  task automatic test_coef_err();
    int y, lat, t;
    wr_coef(1, 0, 16384);
    @(negedge clk); cwe[1] = 1'b1; caddr[1] = 8'd5; cdata[1] = 17'sd8192;
    @(negedge clk); cwe[1] = 1'b0;
    n_checks++; if (cerr[1] !== 1'b1) $display("FAIL err_range_pulse: got %b want 1", cerr[1]); else n_pass++;
    @(negedge clk);
    n_checks++; if (cerr[1] !== 1'b0) $display("FAIL err_range_end: got %b want 0", cerr[1]); else n_pass++;
    send(1, 700, y, lat);
    n_checks++; if (y != 700) $display("FAIL err_range_data: got %0d want 700", y); else n_pass++;
    @(negedge clk); iv[1] = 1'b1; idata[1] = 17'sd700;
    @(negedge clk); iv[1] = 1'b0;
    n_checks++; if (bsy[1] !== 1'b1) $display("FAIL err_busy_state: got %b want 1", bsy[1]); else n_pass++;
    cwe[1] = 1'b1; caddr[1] = 8'd0; cdata[1] = 17'sd0;
    @(negedge clk); cwe[1] = 1'b0;
    n_checks++; if (cerr[1] !== 1'b1) $display("FAIL err_busy_pulse: got %b want 1", cerr[1]); else n_pass++;
    @(negedge clk);
    n_checks++; if (cerr[1] !== 1'b0) $display("FAIL err_busy_end: got %b want 0", cerr[1]); else n_pass++;
    t = 0;
    while (!ov[1] && t < 10) begin @(negedge clk); t++; end
    n_checks++;
    if (ov[1] !== 1'b1 || odata[1] !== 17'sd700) $display("FAIL err_busy_inflight: valid=%b data=%0d want 1 700", ov[1], odata[1]);
    else n_pass++;
    @(negedge clk);
    send(1, 700, y, lat);
    n_checks++; if (y != 700) $display("FAIL err_busy_coef_kept: got %0d want 700", y); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int y, lat, seen;
    @(negedge clk); iv[0] = 1'b1; idata[0] = 17'sd1234;
    @(negedge clk); iv[0] = 1'b0;
    @(negedge clk);
    n_checks++; if (bsy[0] !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", bsy[0]); else n_pass++;
    rst[0] = 1'b1;
    #1;
    n_checks++;
    if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bsy[0] !== 1'b0)
      $display("FAIL rstmid_async: valid=%b ready=%b busy=%b want 0 1 0", ov[0], ir[0], bsy[0]);
    else n_pass++;
    @(negedge clk); rst[0] = 1'b0;
    model_reset(0);
    seen = 0;
    for (int c = 0; c < 120; c++) begin @(negedge clk); if (ov[0]) seen++; end
    n_checks++; if (seen != 0) $display("FAIL rstmid_no_output: got %0d valid cycles want 0", seen); else n_pass++;
    send(0, 1234, y, lat);
    n_checks++; if (y != 1234) $display("FAIL rstmid_identity: got %0d want 1234", y); else n_pass++;
    n_checks++; if (lat != 96) $display("FAIL rstmid_latency: got %0d want 96", lat); else n_pass++;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; iv[u] = 1'b0; idata[u] = '0; ordy[u] = 1'b1;
      cwe[u] = 1'b0; caddr[u] = '0; cdata[u] = '0; clr[u] = 1'b0;
      model_reset(u);
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    test_reset();
    test_identity48();
    test_random48();
    test_gain_half();
    test_decay();
    test_sat();
    test_backpressure();
    test_coef_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
